// File: rtl/qam_pkg.sv
// qam_pkg: shared definitions for the QAM bit scheduler.
//   DIV_W_DEF    - default width of the baud divider and symbol counter
//   BITS_PER_SYM - bits per QAM symbol (fixed by the 2-bit serial-to-parallel stage)
//   state_e      - scheduler FSM states
package qam_pkg;

   localparam int unsigned DIV_W_DEF    = 16;
   localparam int unsigned BITS_PER_SYM = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/qam_bit_scheduler_if.sv
// qam_bit_scheduler_if: valid/ready bit stream from the upstream bit source.
//   bit_valid - source has a bit
//   bit_data  - bit value
//   bit_ready - scheduler accepts the bit this cycle
//   master    - bit source side, slave - scheduler side
interface qam_bit_scheduler_if;

   logic bit_valid;
   logic bit_data;
   logic bit_ready;

   modport master (output bit_valid, output bit_data, input bit_ready);
   modport slave  (input bit_valid, input bit_data, output bit_ready);

endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit-period counter for the QAM bit scheduler.
//   clock, reset_n - system clock, asynchronous active-low reset
//   run            - count while high, hold while low
//   restart        - force the counter back to 0 (wins over run)
//   div            - clocks per bit period; 0 and 1 both tick every cycle
//   tick           - high on the last cycle of each bit period while running
module baud_tick_gen
   import qam_pkg::*;
#(
   parameter int unsigned DIV_W = DIV_W_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             run,
   input  logic             restart,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             every_cycle;

   always_comb begin
      every_cycle = (div <= DIV_W'(1));
      tick        = run && (every_cycle || (cnt_q == div - DIV_W'(1)));
      cnt_d       = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/qam_bit_scheduler.sv
// qam_bit_scheduler: paces an upstream bit stream at the baud rate into the
// 2-bit serial-to-parallel stage and counts completed symbols.
//   clock, reset_n - system clock, asynchronous active-low reset
//   enable         - 1 = schedule bits, 0 = finish the current pair then idle
//   baud_div       - clocks per bit period, latched when leaving IDLE
//   clear_flags    - pulse, clears the sticky underrun flag
//   bus            - bit_valid/bit_data in, bit_ready out (slave modport)
//   adat_be_S      - registered serial bit, valid while data_change is high
//   data_change    - one-cycle strobe per accepted bit
//   sym_strobe     - one-cycle strobe with the second bit of each pair
//   sym_count      - completed-symbol counter (wraps)
//   underrun       - sticky: a bit period elapsed with no bit available
//   busy           - FSM is not IDLE
module qam_bit_scheduler
   import qam_pkg::*;
#(
   parameter int unsigned DIV_W = DIV_W_DEF
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                enable,
   input  logic [DIV_W-1:0]    baud_div,
   input  logic                clear_flags,
   qam_bit_scheduler_if.slave  bus,
   output logic                adat_be_S,
   output logic                data_change,
   output logic                sym_strobe,
   output logic [DIV_W-1:0]    sym_count,
   output logic                underrun,
   output logic                busy
);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] symcnt_q, symcnt_d;
   logic             bit_cnt_q, bit_cnt_d;
   logic             adat_q, adat_d;
   logic             dc_q, dc_d;
   logic             ss_q, ss_d;
   logic             und_q, und_d;

   logic             tick, run, restart, ready, xfer, und_set;

   assign run = (state_q == ST_RUN) || (state_q == ST_DRAIN);

   baud_tick_gen #(.DIV_W(DIV_W)) u_tick (
      .clock   (clock),
      .reset_n (reset_n),
      .run     (run),
      .restart (restart),
      .div     (div_q),
      .tick    (tick)
   );

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      symcnt_d  = symcnt_q;
      bit_cnt_d = bit_cnt_q;
      adat_d    = adat_q;
      dc_d      = 1'b0;
      ss_d      = 1'b0;
      und_set   = 1'b0;
      restart   = 1'b0;

      unique case (state_q)
         ST_RUN, ST_DRAIN: ready = tick;
         ST_STALL:         ready = 1'b1;
         default:          ready = 1'b0;
      endcase
      xfer = bus.bit_valid && ready;

      if (xfer) begin
         adat_d    = bus.bit_data;
         dc_d      = 1'b1;
         bit_cnt_d = ~bit_cnt_q;
         if (bit_cnt_q == 1'(BITS_PER_SYM - 1)) begin
            ss_d     = 1'b1;
            symcnt_d = symcnt_q + DIV_W'(1);
         end
      end

      // Pair completion is judged on the post-transfer bit count, so a bit
      // accepted on the same cycle enable falls is accounted for correctly.
      unique case (state_q)
         ST_IDLE: begin
            if (enable) begin
               div_d   = baud_div;
               restart = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d = (bit_cnt_d == 1'b0) ? ST_IDLE : ST_DRAIN;
            end else if (tick && !bus.bit_valid) begin
               und_set = 1'b1;
               state_d = ST_STALL;
            end
         end
         ST_STALL: begin
            if (xfer) begin
               restart = 1'b1;
               if (enable)                  state_d = ST_RUN;
               else if (bit_cnt_d == 1'b0)  state_d = ST_IDLE;
               else                         state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (tick && !bus.bit_valid) begin
               und_set   = 1'b1;
               bit_cnt_d = 1'b0;
               state_d   = ST_IDLE;
            end else if (xfer && (bit_cnt_d == 1'b0)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      und_d = und_set ? 1'b1 : (clear_flags ? 1'b0 : und_q);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         div_q     <= '0;
         symcnt_q  <= '0;
         bit_cnt_q <= 1'b0;
         adat_q    <= 1'b0;
         dc_q      <= 1'b0;
         ss_q      <= 1'b0;
         und_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         symcnt_q  <= symcnt_d;
         bit_cnt_q <= bit_cnt_d;
         adat_q    <= adat_d;
         dc_q      <= dc_d;
         ss_q      <= ss_d;
         und_q     <= und_d;
      end
   end

   assign bus.bit_ready = ready;
   assign adat_be_S     = adat_q;
   assign data_change   = dc_q;
   assign sym_strobe    = ss_q;
   assign sym_count     = symcnt_q;
   assign underrun      = und_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qam_bit_scheduler.sv
// tb_qam_bit_scheduler: directed bench for qam_bit_scheduler.
// Symbol counter width is reduced to 8 so the wrap case stays short.
module tb_qam_bit_scheduler;

   localparam int unsigned DIV_W_TB = 8;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                enable = 1'b0;
   logic [DIV_W_TB-1:0] baud_div = '0;
   logic                clear_flags = 1'b0;
   logic                adat, dc, ss, underrun, busy;
   logic [DIV_W_TB-1:0] sym_count;

   qam_bit_scheduler_if bus ();

   qam_bit_scheduler #(.DIV_W(DIV_W_TB)) dut (
      .clock       (clk),
      .reset_n     (rst_n),
      .enable      (enable),
      .baud_div    (baud_div),
      .clear_flags (clear_flags),
      .bus         (bus.slave),
      .adat_be_S   (adat),
      .data_change (dc),
      .sym_strobe  (ss),
      .sym_count   (sym_count),
      .underrun    (underrun),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc_n   = 0;
   bit   take_n  = 1'b0;
   bit   auto_stop = 1'b0;
   logic src[$];
   logic dq[$];
   int   tq[$];
   int   sq[$];
   int   hq[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc_n++;

   // Observe handshakes and output strobes mid-cycle.
   always @(negedge clk) begin
      take_n = 1'b0;
      if (rst_n) begin
         if (bus.bit_valid && bus.bit_ready) begin
            take_n = 1'b1;
            hq.push_back(cyc_n);
         end
         if (dc) begin
            dq.push_back(adat);
            tq.push_back(cyc_n);
         end
         if (ss) sq.push_back(cyc_n);
      end
   end

   // Bit source: advance after the edge that consumed the current bit.
   always @(posedge clk) begin
      #2;
      if (take_n && src.size() > 0) begin
         void'(src.pop_front());
         if (src.size() > 0) begin
            bus.bit_data = src[0];
         end else begin
            bus.bit_valid = 1'b0;
            if (auto_stop) enable = 1'b0;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      src.delete(); dq.delete(); tq.delete(); sq.delete(); hq.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b0; clear_flags = 1'b0; auto_stop = 1'b0;
      bus.bit_valid = 1'b0; bus.bit_data = 1'b0;
      clear_logs();
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic load_bits(input int n, input logic [31:0] pat);
      for (int i = 0; i < n; i++) src.push_back(pat[i]);
   endtask

   task automatic start(input logic [DIV_W_TB-1:0] div);
      baud_div = div;
      if (src.size() > 0) begin
         bus.bit_data  = src[0];
         bus.bit_valid = 1'b1;
      end
      enable = 1'b1;
   endtask

   task automatic wait_dc(input string tag, input int n, input int budget);
      int k = 0;
      while (dq.size() < n && k < budget) begin
         step(1);
         k++;
      end
      check_eq(tag, dq.size(), n);
   endtask

   function automatic logic [31:0] packed_bits(input int n);
      logic [31:0] v = '0;
      for (int i = 0; i < n && i < dq.size(); i++) v[i] = dq[i];
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.bit_valid = 1'b0;
      bus.bit_data  = 1'b0;
      step(2);
      check_eq("rst_busy",   busy, 0);
      check_eq("rst_ready",  bus.bit_ready, 0);
      check_eq("rst_dc",     dc, 0);
      check_eq("rst_count",  sym_count, 0);
      check_eq("rst_under",  underrun, 0);

      // baud_div=4, bits 1,0,1,1
      do_reset();
      load_bits(4, 32'b1101);
      auto_stop = 1'b1;
      start(8'd4);
      wait_dc("t1_done", 4, 40);
      check_eq("t1_bits",    packed_bits(4), 32'b1101);
      check_eq("t1_latency", tq[0] - hq[0], 1);
      check_eq("t1_gap01",   tq[1] - tq[0], 4);
      check_eq("t1_gap23",   tq[3] - tq[2], 4);
      check_eq("t1_nstrobe", sq.size(), 2);
      check_eq("t1_strobe0", sq[0], tq[1]);
      check_eq("t1_strobe1", sq[1], tq[3]);
      check_eq("t1_count",   sym_count, 2);
      step(3);
      check_eq("t1_idle",    busy, 0);

      // baud_div=0 then 1, 10 bits each
      do_reset();
      load_bits(10, 32'b1100101101);
      auto_stop = 1'b1;
      start(8'd0);
      wait_dc("t2a_done", 10, 40);
      check_eq("t2a_bits",  packed_bits(10), 32'b1100101101);
      check_eq("t2a_span",  tq[9] - tq[0], 9);
      check_eq("t2a_count", sym_count, 5);
      do_reset();
      load_bits(10, 32'b0110011010);
      auto_stop = 1'b1;
      start(8'd1);
      step(3);
      baud_div = 8'd7;
      wait_dc("t2b_done", 10, 40);
      check_eq("t2b_bits",  packed_bits(10), 32'b0110011010);
      check_eq("t2b_span",  tq[9] - tq[0], 9);
      check_eq("t2b_count", sym_count, 5);

      // baud_div=3, bit_valid low for 5 clocks around the 3rd tick
      do_reset();
      load_bits(4, 32'b1101);
      auto_stop = 1'b1;
      start(8'd3);
      wait_dc("t3_two", 2, 30);
      bus.bit_valid = 1'b0;
      step(3);
      check_eq("t3_under",  underrun, 1);
      check_eq("t3_stall_rdy0", bus.bit_ready, 1);
      step(1);
      check_eq("t3_stall_rdy1", bus.bit_ready, 1);
      check_eq("t3_busy",   busy, 1);
      step(1);
      bus.bit_valid = 1'b1;
      wait_dc("t3_done", 4, 30);
      check_eq("t3_bits",    packed_bits(4), 32'b1101);
      check_eq("t3_gap23",   tq[3] - tq[2], 3);
      check_eq("t3_nstrobe", sq.size(), 2);
      check_eq("t3_strobe1", sq[1], tq[3]);
      check_eq("t3_count",   sym_count, 2);
      step(2);
      check_eq("t3_sticky",  underrun, 1);
      clear_flags = 1'b1;
      step(1);
      clear_flags = 1'b0;
      check_eq("t3_cleared", underrun, 0);

      // enable dropped after the 1st bit of a pair: drain completes it
      do_reset();
      load_bits(4, 32'b0101);
      start(8'd3);
      wait_dc("t4a_three", 3, 40);
      enable = 1'b0;
      step(1);
      check_eq("t4a_drain_busy", busy, 1);
      wait_dc("t4a_done", 4, 20);
      step(2);
      check_eq("t4a_bits",    packed_bits(4), 32'b0101);
      check_eq("t4a_nstrobe", sq.size(), 2);
      check_eq("t4a_count",   sym_count, 2);
      check_eq("t4a_idle",    busy, 0);
      check_eq("t4a_under",   underrun, 0);

      // same, but no bit arrives during drain; clear_flags coincides with the set
      do_reset();
      load_bits(3, 32'b101);
      start(8'd3);
      wait_dc("t4b_three", 3, 40);
      enable = 1'b0;
      step(1);
      clear_flags = 1'b1;
      step(1);
      clear_flags = 1'b0;
      check_eq("t4b_setwins", underrun, 1);
      step(2);
      check_eq("t4b_idle",    busy, 0);
      check_eq("t4b_nstrobe", sq.size(), 1);
      check_eq("t4b_count",   sym_count, 1);
      check_eq("t4b_ndc",     dq.size(), 3);
      load_bits(2, 32'b01);
      auto_stop = 1'b1;
      start(8'd0);
      wait_dc("t4b_more", 5, 20);
      check_eq("t4b_pair_nstrobe", sq.size(), 2);
      check_eq("t4b_pair_strobe",  sq[1], tq[4]);
      check_eq("t4b_pair_count",   sym_count, 2);

      // asynchronous reset mid-pair
      do_reset();
      load_bits(15, 32'h4CB5);
      start(8'd0);
      wait_dc("t5_fifteen", 15, 40);
      check_eq("t5_pre_count", sym_count, 7);
      check_eq("t5_pre_under", underrun, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("t5_async_count", sym_count, 0);
      check_eq("t5_async_under", underrun, 0);
      check_eq("t5_async_busy",  busy, 0);
      check_eq("t5_async_ready", bus.bit_ready, 0);
      check_eq("t5_async_adat",  adat, 0);
      step(1);
      clear_logs();
      enable = 1'b0;
      bus.bit_valid = 1'b0;
      rst_n = 1'b1;
      load_bits(2, 32'b11);
      auto_stop = 1'b1;
      start(8'd0);
      wait_dc("t5_two", 2, 20);
      check_eq("t5_nstrobe", sq.size(), 1);
      check_eq("t5_strobe",  sq[0], tq[1]);
      check_eq("t5_count",   sym_count, 1);

      // symbol counter wrap (8-bit counter: 0xFF + 1 -> 0x00)
      do_reset();
      for (int i = 0; i < 510; i++) src.push_back(1'((i % 3) == 0));
      auto_stop = 1'b1;
      start(8'd0);
      wait_dc("t6_full", 510, 600);
      step(2);
      check_eq("t6_max",   sym_count, 8'hFF);
      load_bits(2, 32'b10);
      start(8'd0);
      wait_dc("t6_wrap_done", 512, 20);
      check_eq("t6_wrap",  sym_count, 0);
      check_eq("t6_under", underrun, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
